// File: rtl/sdes_decrypt_engine.sv
// rtl/sdes_decrypt_engine.sv - multi-cycle FSM-sequenced S-DES decryption engine
module sdes_decrypt_engine (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] key_in,
    input  logic [7:0] ciphertext_in,
    output logic [7:0] plaintext_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] subkey1_out,
    output logic [7:0] subkey2_out,
    output logic [2:0] state_code
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] KEYGEN  = 3'd1;
    localparam logic [2:0] IPERM   = 3'd2;
    localparam logic [2:0] FK_A    = 3'd3;
    localparam logic [2:0] SWAP    = 3'd4;
    localparam logic [2:0] FK_B    = 3'd5;
    localparam logic [2:0] OUTPERM = 3'd6;

    // S-box contents indexed by {row, col}
    localparam logic [1:0] S0 [16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                       2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [1:0] S1 [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                       2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

    logic [2:0] state;
    logic [9:0] key_reg;
    logic [7:0] ct_reg;
    logic [7:0] data;
    logic [9:0] p10;
    logic [9:0] ls1;
    logic [9:0] ls3;
    logic [7:0] k1;
    logic [7:0] k2;

    function automatic logic [7:0] p8(input logic [9:0] x);
        return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] d);
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] d);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    // Mixes the right nibble into the left under subkey k; right nibble passes through
    function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] k);
        logic [7:0] x;
        logic [1:0] s0v;
        logic [1:0] s1v;
        logic [3:0] p4;
        x   = {d[0], d[3], d[2], d[1], d[2], d[1], d[0], d[3]} ^ k;
        s0v = S0[{x[7], x[4], x[6], x[5]}];
        s1v = S1[{x[3], x[0], x[2], x[1]}];
        p4  = {s0v[0], s1v[0], s1v[1], s0v[1]};
        return {d[7:4] ^ p4, d[3:0]};
    endfunction

    always_comb begin
        p10 = {key_reg[7], key_reg[5], key_reg[8], key_reg[3], key_reg[6],
               key_reg[0], key_reg[9], key_reg[1], key_reg[2], key_reg[4]};
        ls1 = {p10[8:5], p10[9], p10[3:0], p10[4]};
        ls3 = {ls1[7:5], ls1[9:8], ls1[2:0], ls1[4:3]};
        k1  = p8(ls1);
        k2  = p8(ls3);
    end

    assign busy       = (state != IDLE);
    assign state_code = state;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= IDLE;
            key_reg       <= '0;
            ct_reg        <= '0;
            data          <= '0;
            plaintext_out <= '0;
            subkey1_out   <= '0;
            subkey2_out   <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg <= key_in;
                        ct_reg  <= ciphertext_in;
                        state   <= KEYGEN;
                    end
                end
                KEYGEN: begin
                    subkey1_out <= k1;
                    subkey2_out <= k2;
                    state       <= IPERM;
                end
                IPERM: begin
                    data  <= ip(ct_reg);
                    state <= FK_A;
                end
                FK_A: begin
                    data  <= fk(data, subkey2_out);
                    state <= SWAP;
                end
                SWAP: begin
                    data  <= {data[3:0], data[7:4]};
                    state <= FK_B;
                end
                FK_B: begin
                    data  <= fk(data, subkey1_out);
                    state <= OUTPERM;
                end
                OUTPERM: begin
                    plaintext_out <= ip_inv(data);
                    done          <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdes_decrypt_engine.sv
// tb/tb_sdes_decrypt_engine.sv - self-checking bench for sdes_decrypt_engine
module tb_sdes_decrypt_engine;

    logic       CLOCK_50;
    logic       reset;
    logic       start;
    logic [9:0] key_in;
    logic [7:0] ciphertext_in;
    logic [7:0] plaintext_out;
    logic       busy;
    logic       done;
    logic [7:0] subkey1_out;
    logic [7:0] subkey2_out;
    logic [2:0] state_code;

    int n_checks = 0;
    int n_fail   = 0;

    sdes_decrypt_engine dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .start         (start),
        .key_in        (key_in),
        .ciphertext_in (ciphertext_in),
        .plaintext_out (plaintext_out),
        .busy          (busy),
        .done          (done),
        .subkey1_out   (subkey1_out),
        .subkey2_out   (subkey2_out),
        .state_code    (state_code)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_T  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    localparam int IP_T  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    localparam int IPI_T [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    localparam int EP_T  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    localparam int P4_T  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    localparam int S0M [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    localparam int S1M [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    // Output bit j (1 = MSB) takes input bit t[j] (1 = MSB)
    function automatic int perm(input int v, input int n_in, input int n_out, input int t[10]);
        int r;
        r = 0;
        for (int j = 0; j < n_out; j++)
            r = r * 2 + ((v >> (n_in - t[j])) & 1);
        return r;
    endfunction

    function automatic int rot5(input int x, input int n);
        return ((x << n) | (x >> (5 - n))) & 31;
    endfunction

    function automatic int model_k(input int key, input int which);
        int p, l, r;
        p = perm(key, 10, 10, P10_T);
        l = rot5(p >> 5, 1);
        r = rot5(p & 31, 1);
        if (which == 2) begin
            l = rot5(l, 2);
            r = rot5(r, 2);
        end
        return perm(l * 32 + r, 10, 8, P8_T);
    endfunction

    function automatic int model_fk(input int d, input int k);
        int l, r, t, a, b, s;
        l = d >> 4;
        r = d & 15;
        t = perm(r, 4, 8, EP_T) ^ k;
        a = t >> 4;
        b = t & 15;
        s = S0M[((a >> 3) & 1) * 2 + (a & 1)][((a >> 2) & 1) * 2 + ((a >> 1) & 1)] * 4
          + S1M[((b >> 3) & 1) * 2 + (b & 1)][((b >> 2) & 1) * 2 + ((b >> 1) & 1)];
        return ((l ^ perm(s, 4, 4, P4_T)) << 4) | r;
    endfunction

    function automatic int model_cipher(input int d, input int ka, input int kb);
        int x;
        x = perm(d, 8, 8, IP_T);
        x = model_fk(x, ka);
        x = ((x & 15) << 4) | (x >> 4);
        x = model_fk(x, kb);
        return perm(x, 8, 8, IPI_T);
    endfunction

    function automatic int model_enc(input int key, input int pt);
        return model_cipher(pt, model_k(key, 1), model_k(key, 2));
    endfunction

    function automatic int model_dec(input int key, input int ct);
        return model_cipher(ct, model_k(key, 2), model_k(key, 1));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Pulses start for one edge, then waits (bounded) for done
    task automatic do_op(input logic [9:0] k, input logic [7:0] ct, output int lat);
        key_in        = k;
        ciphertext_in = ct;
        start         = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    typedef struct {
        logic [9:0] key;
        logic [7:0] ct;
        logic [7:0] pt;
        logic [7:0] k1;
        logic [7:0] k2;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   lat;
        int   exp_codes[8];
        int   done_edges[$];
        logic [7:0] hold_pt, hold_k1, hold_k2;
        int   pt, ct;

        reset = 1'b1;
        start = 1'b0;
        key_in = '0;
        ciphertext_in = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_pt", plaintext_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_k1", subkey1_out, 0);
        check("reset_k2", subkey2_out, 0);
        check("reset_state", state_code, 0);

        // Known vector with full state trace
        exp_codes = '{1, 2, 3, 4, 5, 6, 0, 0};
        key_in = 10'b1010000010;
        ciphertext_in = 8'b00111000;
        start = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            start = 1'b0;
            check($sformatf("trace_state_e%0d", e), state_code, exp_codes[e]);
            check($sformatf("trace_done_e%0d", e), done, (e == 6) ? 1 : 0);
            check($sformatf("trace_busy_e%0d", e), busy, (e < 6) ? 1 : 0);
            if (e == 1) begin
                check("trace_k1", subkey1_out, 8'b10100100);
                check("trace_k2", subkey2_out, 8'b01000011);
            end
        end
        check("trace_pt", plaintext_out, 8'b10010111);

        // Table-driven vectors
        vecs[0] = '{10'b1010000010, 8'b00111000, 8'b10010111, 8'b10100100, 8'b01000011};
        vecs[1] = '{10'h000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{10'h3FF, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{10'h2AA, 8'h55, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{10'($urandom_range(1023)), 8'($urandom_range(255)), 8'h00, 8'h00, 8'h00};
        vecs[5] = '{10'($urandom_range(1023)), 8'($urandom_range(255)), 8'h00, 8'h00, 8'h00};
        for (int i = 1; i < 6; i++) begin
            vecs[i].pt = 8'(model_dec(vecs[i].key, vecs[i].ct));
            vecs[i].k1 = 8'(model_k(vecs[i].key, 1));
            vecs[i].k2 = 8'(model_k(vecs[i].key, 2));
        end
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].key, vecs[i].ct, lat);
            check($sformatf("vec%0d_latency", i), lat, 6);
            check($sformatf("vec%0d_pt", i), plaintext_out, vecs[i].pt);
            check($sformatf("vec%0d_k1", i), subkey1_out, vecs[i].k1);
            check($sformatf("vec%0d_k2", i), subkey2_out, vecs[i].k2);
        end
        tick();

        // start held for 20 edges; ciphertext changes after edge 3
        key_in = 10'h1B3;
        ciphertext_in = 8'hA7;
        start = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (e == 3) ciphertext_in = 8'h3C;
            if (done) done_edges.push_back(e);
            if (e == 6) check("held_first_pt", plaintext_out, model_dec(10'h1B3, 8'hA7));
            if (e == 13) check("held_second_pt", plaintext_out, model_dec(10'h1B3, 8'h3C));
        end
        start = 1'b0;
        check("held_done_count", done_edges.size(), 2);
        if (done_edges.size() == 2) begin
            check("held_done_edge_a", done_edges[0], 6);
            check("held_done_edge_b", done_edges[1], 13);
        end
        lat = 0;
        while (busy && lat < 20) begin
            tick();
            lat++;
        end
        check("held_drain_idle", busy, 0);
        tick();

        // Reset while in FK_A
        key_in = 10'h0F0;
        ciphertext_in = 8'h81;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midreset_in_fka", state_code, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_pt", plaintext_out, 0);
        check("midreset_k1", subkey1_out, 0);
        check("midreset_k2", subkey2_out, 0);
        check("midreset_state", state_code, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        lat = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (done || busy) lat++;
        end
        check("midreset_no_done", lat, 0);
        do_op(10'h0F0, 8'h81, lat);
        check("midreset_fresh_lat", lat, 6);
        check("midreset_fresh_pt", plaintext_out, model_dec(10'h0F0, 8'h81));
        tick();

        // Reset and start on the same edge
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_state", state_code, 0);
        check("rst_start_busy", busy, 0);
        tick();
        check("rst_start_state2", state_code, 0);
        check("rst_start_busy2", busy, 0);

        // Idle hold after a completion
        do_op(10'h355, 8'hC3, lat);
        check("hold_setup_pt", plaintext_out, model_dec(10'h355, 8'hC3));
        hold_pt = plaintext_out;
        hold_k1 = subkey1_out;
        hold_k2 = subkey2_out;
        key_in = 10'h0AA;
        ciphertext_in = 8'h11;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (plaintext_out != hold_pt || subkey1_out != hold_k1 ||
                subkey2_out != hold_k2 || done)
                check($sformatf("idle_hold_c%0d", e), 0, 1);
        end
        check("idle_hold_pt", plaintext_out, model_dec(10'h355, 8'hC3));
        check("idle_hold_k1", subkey1_out, model_k(10'h355, 1));
        check("idle_hold_k2", subkey2_out, model_k(10'h355, 2));
        check("idle_hold_done", done, 0);

        // Round trip over every key
        for (int k = 0; k < 1024; k++) begin
            for (int p = 0; p < 4; p++) begin
                pt = $urandom_range(255);
                ct = model_enc(k, pt);
                do_op(10'(k), 8'(ct), lat);
                if (lat != 6 || plaintext_out != 8'(pt))
                    check($sformatf("roundtrip_k%0d_pt%0h_lat%0d", k, pt, lat), plaintext_out, pt);
                else
                    n_checks++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
